// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W       = 8;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } src_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Two-requester grant select: DM wins ties; with ARB_FAIRNESS_EN a starve
// counter hands the port to IF after STARVE_LIMIT consecutive DM wins.
module mem_arb_sel
  import mem_arb_pkg::*;
`ifdef ARB_FAIRNESS_EN
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
)
`endif
(
`ifdef ARB_FAIRNESS_EN
  input  logic       clk,
`endif
  input  logic       rst,
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       mem_ready,
  output logic [1:0] gnt       // bit 0 = IF, bit 1 = DM
);

  logic force_if;

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign force_if = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts DM wins while IF is left waiting; any IF grant or idle IF clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!if_req || gnt[0]) begin
      starve_cnt <= '0;
    end else if (gnt[1] && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    gnt = 2'b00;
    if (rst && mem_ready) begin
      if (dm_req && !(if_req && force_if)) begin
        gnt[1] = 1'b1;
      end else if (if_req) begin
        gnt[0] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Optional IF anti-starvation enabled by defining ARB_FAIRNESS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
`ifdef ARB_FAIRNESS_EN
  , parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              mem_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic [1:0]        gnt;
  logic              resp_v;
  src_t              resp_src;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

`ifdef ARB_FAIRNESS_EN
  mem_arb_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk       (clk),
`else
  mem_arb_sel u_sel (
`endif
    .rst       (rst),
    .if_req    (if_req),
    .dm_req    (dm_req),
    .mem_ready (mem_ready),
    .gnt       (gnt)
  );

  assign if_gnt = gnt[0];
  assign dm_gnt = gnt[1];

  // Request mux toward memory; idle port drives zeros.
  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // One-deep response pipe; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_v   <= 1'b0;
      resp_src <= SRC_IF;
    end else begin
      resp_v   <= if_gnt | (dm_gnt & ~dm_we);
      resp_src <= dm_gnt ? SRC_DM : SRC_IF;
    end
  end

  assign busy      = resp_v;
  assign if_rvalid = resp_v & (resp_src == SRC_IF);
  assign dm_rvalid = resp_v & (resp_src == SRC_DM);

  // Read data is presented straight from memory in the response cycle, then held.
  always_ff @(posedge clk) begin
    if (if_rvalid) if_rdata_q <= mem_rdata;
    if (dm_rvalid) dm_rdata_q <= mem_rdata;
  end

  assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
  assign dm_rdata = dm_rvalid ? mem_rdata : dm_rdata_q;

endmodule
